eth_tx_arbiter: RTL
===================

Name: eth_tx_arbiter

Overview:
- Shares the RMII transmit dibit path between NREQ frame sources.
- Grants the path round-robin and prepends preamble/SFD itself.
- Streams the granted source's dibits to the PHY and enforces the interframe gap and a maximum frame length.
- Output stream uses the same axiov/axiod dibit convention as the receive-side dibit blocks.

Parameters:
- NREQ, 2, number of requesters (2..8).
- PRE_DIBITS, 32, preamble+SFD length in dibits (7x 0x55 + 0xD5, LSB-first).
- IFG_DIBITS, 48, interframe gap in dibit cycles (96 bit times).
- MAX_DIBITS, 6072, maximum payload dibits per frame (1518 bytes).

Ports:
- clk  in  1  50 MHz RMII reference clock.
- rst  in  1  async, active-high reset.
- req  in  NREQ  per-requester frame-pending request, level.
- grant  out  NREQ  one-hot grant; high from first preamble dibit until the frame ends.
- start  out  1  one-cycle pulse telling the granted source to begin driving data next cycle.
- src_axiiv  in  NREQ  per-source payload valid.
- src_axiid  in  2*NREQ  per-source payload dibit; source i uses bits [2i+1:2i].
- axiov  out  1  PHY tx enable (TXEN).
- axiod  out  2  PHY tx dibit (TXD).
- done  out  1  one-cycle pulse: frame ended normally.
- err  out  1  one-cycle pulse: empty frame or length truncation.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-high.
  - Every output is registered.
  - Reset forces, immediately and also mid-frame: grant=0, start=0, axiov=0, axiod=0, done=0, err=0, state IDLE, counters 0.
  - Reset sets the round-robin pointer to NREQ-1, so req[0] wins first.
- States:
  - IDLE -> PREAMBLE when any req is high.
  - PREAMBLE -> PAYLOAD after PRE_DIBITS cycles.
  - PAYLOAD -> GAP when the frame ends.
  - GAP -> PREAMBLE if any req is high on its final cycle; otherwise GAP -> IDLE.
- Arbitration:
  - Choose the lowest index after the last granted index whose req is high, wrapping.
  - The selection is latched at grant.
  - req changes during PREAMBLE/PAYLOAD are ignored; dropping req does not abort the frame.
- PREAMBLE (cycle index p = 0..PRE_DIBITS-1, grant already high at p=0):
  - axiov=1 throughout.
  - axiod=01 for p<PRE_DIBITS-1; axiod=11 at p=PRE_DIBITS-1.
  - start=1 exactly at p=PRE_DIBITS-2.
- Source obligation: drive valid data from cycle p=PRE_DIBITS-1 onward, contiguously. A registered source reacting to start meets this.
- PAYLOAD:
  - Each edge samples the granted source's axiiv/axiid. This includes the edge ending p=PRE_DIBITS-1.
  - Valid high: axiov<=1, axiod<=dibit, count+1. Latency is 1 cycle, so the output is contiguous with the SFD.
  - Valid low with count>0: axiov<=0, done<=1, grant<=0, enter GAP.
  - Valid low on the first sample (count==0), i.e. an empty frame: axiov<=0, err<=1, no done, grant<=0, enter GAP.
  - Valid high with count==MAX_DIBITS: truncate; axiov<=0, err<=1, grant<=0, enter GAP. The dibit is discarded.
  - Non-granted sources' inputs are ignored at all times.
- GAP:
  - axiov=0 for exactly IFG_DIBITS cycles, counted from the first low cycle after the frame.
  - On the last GAP edge a pending request is granted directly, so the next preamble dibit follows with exactly IFG_DIBITS idle cycles.
  - A request arriving during GAP waits; it is never lost.
- Widths:
  - Payload counter is $clog2(MAX_DIBITS+1) bits.
  - Shared phase counter is $clog2(max(PRE_DIBITS,IFG_DIBITS)) bits.
  - No wrap is possible, because truncation fires first.
- Simultaneous events: done/err and a new grant never coincide, since GAP always separates them.

Decomposition:
- Package eth_pkg holds:
  - state enum tx_state_t {IDLE, PREAMBLE, PAYLOAD, GAP};
  - PRE_DIBIT=2'b01 and SFD_LAST_DIBIT=2'b11;
  - default IFG/MAX constants.
- One sub-module: rr_picker.
  - Combinational.
  - Inputs: req vector and last-grant index.
  - Outputs: one-hot next grant and a valid flag.
  - Also reusable for a receive-side consumer arbiter.

Test Plan:
- req=01 after reset:
  - grant=01 with axiov rising the same cycle;
  - 31 dibits of 01 then one 11;
  - start pulses at preamble cycle 30;
  - a 4-dibit source frame (00,01,10,11) appears on axiod on the 4 cycles immediately after the SFD dibit;
  - then axiov=0 and done=1.
- req=11 held continuously: grants alternate 01,10,01; measured axiov-low gap between frames is exactly 48 cycles.
- Source never asserts valid after start: axiov drops right after the SFD dibit, err=1, done=0, 48-cycle gap, then return to IDLE.
- Source holds valid for 6100 dibits: exactly 6072 payload dibits are output, then axiov=0, err=1, grant=0.
- Async reset asserted mid-payload (between clock edges): axiov, grant, start, done and err go to 0 immediately. After release with req=10, requester 1 gets a full preamble from scratch.
- req[1] raised during requester 0's payload and req[0] dropped mid-frame: frame 0 completes unaltered; requester 1 is granted exactly 48 cycles after frame 0's last dibit.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, line-code dibits and default sizing for the RMII transmit path.
package eth_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} tx_state_t;
  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;
  localparam int DEF_PRE_DIBITS = 32;
  localparam int DEF_IFG_DIBITS = 48;
  localparam int DEF_MAX_DIBITS = 6072;
endpackage

// File: rtl/eth_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin choice of the first requester after last, wrapping.
// Ports: req (request vector), last (index granted last time), gnt (one-hot pick),
//        idx (index of the pick), valid (some request is pending).
module rr_picker #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);
  always_comb begin
    gnt = '0;
    idx = '0;
    valid = 1'b0;
    // Walk from farthest to nearest so the nearest pending requester after last is kept.
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        gnt = '0;
        gnt[(int'(last) + k) % NREQ] = 1'b1;
        idx = IW'((int'(last) + k) % NREQ);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin sharing of the RMII tx dibit path with preamble/SFD insertion, IFG and length limit.
// Ports: clk, rst (async, active-high); req (per-source frame pending); grant (one-hot owner);
//        start (pulse: source drives data from next cycle); src_axiiv/src_axiid (per-source payload);
//        axiov/axiod (TXEN/TXD); done (frame ended normally); err (empty or truncated frame).
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PRE_DIBITS = DEF_PRE_DIBITS,
  parameter int IFG_DIBITS = DEF_IFG_DIBITS,
  parameter int MAX_DIBITS = DEF_MAX_DIBITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic              start,
  input  logic [NREQ-1:0]   src_axiiv,
  input  logic [2*NREQ-1:0] src_axiid,
  output logic              axiov,
  output logic [1:0]        axiod,
  output logic              done,
  output logic              err
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_DIBITS + 1);
  localparam int PW = $clog2(PRE_DIBITS > IFG_DIBITS ? PRE_DIBITS : IFG_DIBITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIBITS - 1);
  localparam logic [PW-1:0] PRE_START = PW'(PRE_DIBITS - 2);
  localparam logic [PW-1:0] IFG_LAST = PW'(IFG_DIBITS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIBITS);
  tx_state_t state, state_n;
  logic [PW-1:0] pc, pc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] last, last_n, pick_idx;
  logic [NREQ-1:0] grant_n, pick_gnt;
  logic start_n, axiov_n, done_n, err_n, pick_valid, v, launch, sample;
  logic [1:0] axiod_n, d;
  rr_picker #(.NREQ(NREQ)) u_pick (
    .req(req), .last(last), .gnt(pick_gnt), .idx(pick_idx), .valid(pick_valid)
  );
  assign v = src_axiiv[last];
  assign d = src_axiid[{last, 1'b0} +: 2];
  // The edge ending the SFD dibit already samples the source, so the first payload dibit abuts the SFD.
  assign sample = state == PAYLOAD || (state == PREAMBLE && pc == PRE_LAST);
  assign launch = pick_valid && (state == IDLE || (state == GAP && pc == IFG_LAST));
  always_comb begin
    state_n = state;
    pc_n = pc;
    cnt_n = cnt;
    last_n = last;
    grant_n = grant;
    start_n = 1'b0;
    axiov_n = axiov;
    axiod_n = axiod;
    done_n = 1'b0;
    err_n = 1'b0;
    if (launch) begin
      state_n = PREAMBLE;
      pc_n = '0;
      cnt_n = '0;
      last_n = pick_idx;
      grant_n = pick_gnt;
      axiov_n = 1'b1;
      axiod_n = PRE_DIBIT;
      start_n = PRE_START == '0;
    end else if (sample) begin
      if (v && cnt != CNT_MAX) begin
        state_n = PAYLOAD;
        axiov_n = 1'b1;
        axiod_n = d;
        cnt_n = cnt + 1'b1;
      end else begin
        state_n = GAP;
        pc_n = '0;
        grant_n = '0;
        axiov_n = 1'b0;
        axiod_n = 2'b00;
        done_n = !v && cnt != '0;
        err_n = v || cnt == '0;
      end
    end else if (state == PREAMBLE) begin
      pc_n = pc + 1'b1;
      axiod_n = pc_n == PRE_LAST ? SFD_LAST_DIBIT : PRE_DIBIT;
      start_n = pc_n == PRE_START;
    end else if (state == GAP) begin
      pc_n = pc == IFG_LAST ? '0 : pc + 1'b1;
      state_n = pc == IFG_LAST ? IDLE : GAP;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      cnt <= '0;
      last <= IW'(NREQ - 1);
      grant <= '0;
      start <= 1'b0;
      axiov <= 1'b0;
      axiod <= 2'b00;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      cnt <= cnt_n;
      last <= last_n;
      grant <= grant_n;
      start <= start_n;
      axiov <= axiov_n;
      axiod <= axiod_n;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule
